// File: rtl/axi_mem_slave_pkg.sv
// ============================================================================
// Module   : axi_mem_slave_pkg
// Brief    : Shared AXI types, burst/response encodings for axi_mem_slave.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package axi_mem_slave_pkg;

    localparam int unsigned c_ID_W_WIDTH = 4;
    localparam int unsigned c_ID_R_WIDTH = 4;
    localparam int unsigned c_ADDR_WIDTH = 16;
    localparam int unsigned c_DATA_WIDTH = 8;

    localparam logic [1:0] c_BURST_FIXED = 2'b00;
    localparam logic [1:0] c_BURST_INCR  = 2'b01;
    localparam logic [1:0] c_BURST_WRAP  = 2'b10;

    localparam logic [1:0] c_RESP_OKAY   = 2'b00;
    localparam logic [1:0] c_RESP_SLVERR = 2'b10;

    typedef struct packed {
        logic [c_ID_W_WIDTH-1:0] awid;
        logic [c_ADDR_WIDTH-1:0] awaddr;
        logic [7:0]              awlen;
        logic [1:0]              awburst;
        logic                    awvalid;
        logic [c_DATA_WIDTH-1:0] wdata;
        logic                    wlast;
        logic                    wvalid;
        logic                    bready;
        logic [c_ID_R_WIDTH-1:0] arid;
        logic [c_ADDR_WIDTH-1:0] araddr;
        logic [7:0]              arlen;
        logic [1:0]              arburst;
        logic                    arvalid;
        logic                    rready;
    } axi_mosi_t;

    typedef struct packed {
        logic                    awready;
        logic                    wready;
        logic [c_ID_W_WIDTH-1:0] bid;
        logic [1:0]              bresp;
        logic                    bvalid;
        logic                    arready;
        logic [c_ID_R_WIDTH-1:0] rid;
        logic [c_DATA_WIDTH-1:0] rdata;
        logic [1:0]              rresp;
        logic                    rlast;
        logic                    rvalid;
    } axi_miso_t;

    // Only FIXED and INCR are honoured; anything else is served as INCR with SLVERR.
    function automatic logic burst_supported(input logic [1:0] burst);
        return (burst == c_BURST_FIXED) || (burst == c_BURST_INCR);
    endfunction

endpackage

`default_nettype wire

// File: rtl/axi_mem_slave_array.sv
// ============================================================================
// Module   : axi_mem_slave_array
// Brief    : DEPTH x DATA_WIDTH storage, one write port, combinational read.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module axi_mem_slave_array #(
    parameter int unsigned DEPTH      = 256,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_W     = 8
) (
    input  logic                  clk,
    input  logic                  i_we,
    input  logic [ADDR_W-1:0]     i_waddr,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    input  logic [ADDR_W-1:0]     i_raddr,
    output logic [DATA_WIDTH-1:0] o_rdata
);

    logic [DATA_WIDTH-1:0] r_mem [0:DEPTH-1];

    // Contents are deliberately left unreset.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

`default_nettype wire

// File: rtl/axi_mem_slave.sv
// ============================================================================
// Module   : axi_mem_slave
// Brief    : Single-outstanding AXI memory slave with round-robin AW/AR grant.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module axi_mem_slave
    import axi_mem_slave_pkg::*;
#(
    parameter int unsigned ID_W_WIDTH     = c_ID_W_WIDTH,
    parameter int unsigned ID_R_WIDTH     = c_ID_R_WIDTH,
    parameter int unsigned ADDR_WIDTH     = c_ADDR_WIDTH,
    parameter int unsigned AXI_DATA_WIDTH = c_DATA_WIDTH,
    parameter int unsigned MEM_DEPTH      = 256
) (
    input  logic      clk,
    input  logic      rst_n,
    input  axi_mosi_t in_mosi_i,
    output axi_miso_t in_miso_o
);

    localparam int unsigned c_BYTES      = AXI_DATA_WIDTH / 8;
    localparam int unsigned c_BYTE_SHIFT = $clog2(c_BYTES);
    localparam int unsigned c_MEM_AW     = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_WRITE = 2'd1;
    localparam logic [1:0] c_WRESP = 2'd2;
    localparam logic [1:0] c_READ  = 2'd3;

    logic [1:0]            r_state,   w_state_nxt;
    logic                  r_prio_rd, w_prio_rd_nxt;
    logic [ID_W_WIDTH-1:0] r_awid,    w_awid_nxt;
    logic [ID_R_WIDTH-1:0] r_arid,    w_arid_nxt;
    logic [ADDR_WIDTH-1:0] r_addr,    w_addr_nxt;
    logic [7:0]            r_len,     w_len_nxt;
    logic [1:0]            r_burst,   w_burst_nxt;
    logic [7:0]            r_cnt,     w_cnt_nxt;
    logic                  r_err,     w_err_nxt;

    logic [ADDR_WIDTH-1:0]     w_idx;
    logic                      w_in_range;
    logic [c_MEM_AW-1:0]       w_mem_addr;
    logic [ADDR_WIDTH-1:0]     w_addr_step;
    logic                      w_last;
    logic                      w_we;
    logic [AXI_DATA_WIDTH-1:0] w_rdata;
    logic                      w_awready;
    logic                      w_arready;

    assign w_idx       = r_addr >> c_BYTE_SHIFT;
    assign w_in_range  = (32'(w_idx) < MEM_DEPTH);
    assign w_mem_addr  = w_idx[c_MEM_AW-1:0];
    assign w_addr_step = (r_burst == c_BURST_FIXED) ? r_addr : r_addr + ADDR_WIDTH'(c_BYTES);
    assign w_last      = (r_cnt == r_len);

    // Readies stay low in reset; on contention only the pointed-to channel is ready.
    assign w_awready = rst_n && (r_state == c_IDLE) && !(in_mosi_i.arvalid && r_prio_rd);
    assign w_arready = rst_n && (r_state == c_IDLE) && !(in_mosi_i.awvalid && !r_prio_rd);

    axi_mem_slave_array #(
        .DEPTH      (MEM_DEPTH),
        .DATA_WIDTH (AXI_DATA_WIDTH),
        .ADDR_W     (c_MEM_AW)
    ) u_array (
        .clk     (clk),
        .i_we    (w_we),
        .i_waddr (w_mem_addr),
        .i_wdata (in_mosi_i.wdata[AXI_DATA_WIDTH-1:0]),
        .i_raddr (w_mem_addr),
        .o_rdata (w_rdata)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= c_IDLE;
            r_prio_rd <= 1'b0;
            r_awid    <= '0;
            r_arid    <= '0;
            r_addr    <= '0;
            r_len     <= '0;
            r_burst   <= '0;
            r_cnt     <= '0;
            r_err     <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_prio_rd <= w_prio_rd_nxt;
            r_awid    <= w_awid_nxt;
            r_arid    <= w_arid_nxt;
            r_addr    <= w_addr_nxt;
            r_len     <= w_len_nxt;
            r_burst   <= w_burst_nxt;
            r_cnt     <= w_cnt_nxt;
            r_err     <= w_err_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_prio_rd_nxt = r_prio_rd;
        w_awid_nxt    = r_awid;
        w_arid_nxt    = r_arid;
        w_addr_nxt    = r_addr;
        w_len_nxt     = r_len;
        w_burst_nxt   = r_burst;
        w_cnt_nxt     = r_cnt;
        w_err_nxt     = r_err;
        w_we          = 1'b0;
        in_miso_o     = '0;
        in_miso_o.awready = w_awready;
        in_miso_o.arready = w_arready;

        case (r_state)
            c_IDLE: begin
                if (in_mosi_i.awvalid && w_awready) begin
                    w_awid_nxt    = in_mosi_i.awid[ID_W_WIDTH-1:0];
                    w_addr_nxt    = in_mosi_i.awaddr[ADDR_WIDTH-1:0];
                    w_len_nxt     = in_mosi_i.awlen;
                    w_burst_nxt   = in_mosi_i.awburst;
                    w_cnt_nxt     = '0;
                    w_err_nxt     = !burst_supported(in_mosi_i.awburst);
                    w_prio_rd_nxt = 1'b1;
                    w_state_nxt   = c_WRITE;
                end else if (in_mosi_i.arvalid && w_arready) begin
                    w_arid_nxt    = in_mosi_i.arid[ID_R_WIDTH-1:0];
                    w_addr_nxt    = in_mosi_i.araddr[ADDR_WIDTH-1:0];
                    w_len_nxt     = in_mosi_i.arlen;
                    w_burst_nxt   = in_mosi_i.arburst;
                    w_cnt_nxt     = '0;
                    w_err_nxt     = !burst_supported(in_mosi_i.arburst);
                    w_prio_rd_nxt = 1'b0;
                    w_state_nxt   = c_READ;
                end
            end

            c_WRITE: begin
                in_miso_o.wready = 1'b1;
                if (in_mosi_i.wvalid) begin
                    // Beat count alone ends the burst; a misplaced WLAST only flags an error.
                    w_we       = w_in_range;
                    w_err_nxt  = r_err || !w_in_range || (in_mosi_i.wlast != w_last);
                    w_addr_nxt = w_addr_step;
                    w_cnt_nxt  = r_cnt + 8'd1;
                    if (w_last) begin
                        w_state_nxt = c_WRESP;
                    end
                end
            end

            c_WRESP: begin
                in_miso_o.bvalid = 1'b1;
                in_miso_o.bid    = c_ID_W_WIDTH'(r_awid);
                in_miso_o.bresp  = r_err ? c_RESP_SLVERR : c_RESP_OKAY;
                if (in_mosi_i.bready) begin
                    w_state_nxt = c_IDLE;
                end
            end

            c_READ: begin
                in_miso_o.rvalid = 1'b1;
                in_miso_o.rid    = c_ID_R_WIDTH'(r_arid);
                in_miso_o.rdata  = w_in_range ? c_DATA_WIDTH'(w_rdata) : '0;
                in_miso_o.rresp  = (!w_in_range || r_err) ? c_RESP_SLVERR : c_RESP_OKAY;
                in_miso_o.rlast  = w_last;
                if (in_mosi_i.rready) begin
                    w_addr_nxt = w_addr_step;
                    w_cnt_nxt  = r_cnt + 8'd1;
                    if (w_last) begin
                        w_state_nxt = c_IDLE;
                    end
                end
            end

            default: w_state_nxt = c_IDLE;
        endcase
    end

endmodule

`default_nettype wire

// File: tb/tb_axi_mem_slave.sv
// ============================================================================
// Module   : tb_axi_mem_slave
// Brief    : Directed self-checking bench for axi_mem_slave.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_axi_mem_slave;
    import axi_mem_slave_pkg::*;

    localparam int c_TIMEOUT = 20;

    logic      clk = 1'b0;
    logic      rst_n;
    axi_mosi_t mosi;
    axi_miso_t miso;

    int         n_vec = 0;
    int         n_err = 0;
    logic [7:0] r_exp [0:15];

    axi_mem_slave #(
        .ID_W_WIDTH     (4),
        .ID_R_WIDTH     (4),
        .ADDR_WIDTH     (16),
        .AXI_DATA_WIDTH (8),
        .MEM_DEPTH      (256)
    ) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_mosi_i (mosi),
        .in_miso_o (miso)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic write_burst(input logic [3:0] id, input logic [15:0] addr, input logic [7:0] len,
                               input logic [1:0] burst, input int wlast_beat, input logic [1:0] exp_resp);
        mosi.awid = id; mosi.awaddr = addr; mosi.awlen = len; mosi.awburst = burst;
        mosi.awvalid = 1'b1;
        #1;
        for (int t = 0; t < c_TIMEOUT && !miso.awready; t++) begin @(posedge clk); #1; end
        chk("awready", miso.awready, 1);
        @(posedge clk); #1;
        mosi.awvalid = 1'b0;
        for (int b = 0; b <= int'(len); b++) begin
            mosi.wdata = r_exp[b]; mosi.wlast = (b + 1 == wlast_beat); mosi.wvalid = 1'b1;
            #1;
            for (int t = 0; t < c_TIMEOUT && !miso.wready; t++) begin @(posedge clk); #1; end
            chk("wready", miso.wready, 1);
            @(posedge clk); #1;
        end
        mosi.wvalid = 1'b0; mosi.wlast = 1'b0;
        mosi.bready = 1'b1;
        #1;
        for (int t = 0; t < c_TIMEOUT && !miso.bvalid; t++) begin @(posedge clk); #1; end
        chk("bvalid", miso.bvalid, 1);
        chk("bid", miso.bid, id);
        chk("bresp", miso.bresp, exp_resp);
        @(posedge clk); #1;
        mosi.bready = 1'b0;
    endtask

    task automatic read_burst(input logic [3:0] id, input logic [15:0] addr, input logic [7:0] len,
                              input logic [1:0] burst, input logic [1:0] exp_resp, input int stall);
        mosi.arid = id; mosi.araddr = addr; mosi.arlen = len; mosi.arburst = burst;
        mosi.arvalid = 1'b1;
        #1;
        for (int t = 0; t < c_TIMEOUT && !miso.arready; t++) begin @(posedge clk); #1; end
        chk("arready", miso.arready, 1);
        @(posedge clk); #1;
        mosi.arvalid = 1'b0;
        chk("rvalid_lat", miso.rvalid, 1);
        for (int b = 0; b <= int'(len); b++) begin
            if (b == 0) begin
                for (int s = 0; s < stall; s++) begin
                    chk("stall_rvalid", miso.rvalid, 1);
                    chk("stall_rdata", miso.rdata, r_exp[0]);
                    chk("stall_rid", miso.rid, id);
                    chk("stall_rlast", miso.rlast, (len == 8'd0));
                    @(posedge clk); #1;
                end
            end
            mosi.rready = 1'b1;
            #1;
            for (int t = 0; t < c_TIMEOUT && !miso.rvalid; t++) begin @(posedge clk); #1; end
            chk("rvalid", miso.rvalid, 1);
            chk("rdata", miso.rdata, r_exp[b]);
            chk("rresp", miso.rresp, exp_resp);
            chk("rid", miso.rid, id);
            chk("rlast", miso.rlast, (b == int'(len)));
            @(posedge clk); #1;
            mosi.rready = 1'b0;
        end
        chk("rvalid_end", miso.rvalid, 0);
    endtask

    initial begin
        mosi  = '0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_miso", 64'(miso), 64'd0);
        rst_n = 1'b1;
        #1;
        chk("idle_awready", miso.awready, 1);
        chk("idle_arready", miso.arready, 1);
        chk("idle_other", {miso.wready, miso.bvalid, miso.rvalid}, 0);

        // Simultaneous AW/AR after reset: write first, then read.
        mosi.awid = 4'h3; mosi.awaddr = 16'h0040; mosi.awlen = 8'd0; mosi.awburst = c_BURST_INCR;
        mosi.arid = 4'h5; mosi.araddr = 16'h0040; mosi.arlen = 8'd0; mosi.arburst = c_BURST_INCR;
        mosi.awvalid = 1'b1; mosi.arvalid = 1'b1;
        #1;
        chk("arb1_awready", miso.awready, 1);
        chk("arb1_arready", miso.arready, 0);
        @(posedge clk); #1;
        mosi.awvalid = 1'b0; mosi.arvalid = 1'b0;
        mosi.wdata = 8'h77; mosi.wlast = 1'b1; mosi.wvalid = 1'b1;
        #1;
        chk("arb1_wready", miso.wready, 1);
        @(posedge clk); #1;
        mosi.wvalid = 1'b0; mosi.wlast = 1'b0; mosi.bready = 1'b1;
        #1;
        chk("arb1_bvalid", miso.bvalid, 1);
        chk("arb1_bresp", miso.bresp, c_RESP_OKAY);
        chk("arb1_bid", miso.bid, 4'h3);
        @(posedge clk); #1;
        mosi.bready = 1'b0;
        mosi.awvalid = 1'b1; mosi.arvalid = 1'b1;
        #1;
        chk("arb2_awready", miso.awready, 0);
        chk("arb2_arready", miso.arready, 1);
        @(posedge clk); #1;
        mosi.awvalid = 1'b0; mosi.arvalid = 1'b0;
        chk("arb2_rvalid", miso.rvalid, 1);
        chk("arb2_rdata", miso.rdata, 8'h77);
        chk("arb2_rid", miso.rid, 4'h5);
        chk("arb2_rlast", miso.rlast, 1);
        mosi.rready = 1'b1;
        @(posedge clk); #1;
        mosi.rready = 1'b0;
        chk("arb2_idle", {miso.rvalid, miso.awready}, 2'b01);

        // INCR burst write then read back.
        for (int i = 0; i < 4; i++) r_exp[i] = 8'hA1 + 8'(i);
        write_burst(4'h2, 16'h0010, 8'd3, c_BURST_INCR, 4, c_RESP_OKAY);
        read_burst(4'h6, 16'h0010, 8'd3, c_BURST_INCR, c_RESP_OKAY, 0);

        // Read with RREADY held low for 5 cycles.
        read_burst(4'h9, 16'h0010, 8'd1, c_BURST_INCR, c_RESP_OKAY, 5);

        // Out-of-range write and read; aliased word 0 must be untouched.
        r_exp[0] = 8'h5A;
        write_burst(4'h1, 16'h0000, 8'd0, c_BURST_INCR, 1, c_RESP_OKAY);
        r_exp[0] = 8'hEE;
        write_burst(4'h4, 16'h0100, 8'd0, c_BURST_INCR, 1, c_RESP_SLVERR);
        r_exp[0] = 8'h00;
        read_burst(4'h7, 16'h0100, 8'd0, c_BURST_INCR, c_RESP_SLVERR, 0);
        r_exp[0] = 8'h5A;
        read_burst(4'h7, 16'h0000, 8'd0, c_BURST_INCR, c_RESP_OKAY, 0);

        // Early WLAST: all three beats land, response is SLVERR.
        r_exp[0] = 8'h31; r_exp[1] = 8'h32; r_exp[2] = 8'h33;
        write_burst(4'hA, 16'h0030, 8'd2, c_BURST_INCR, 2, c_RESP_SLVERR);
        read_burst(4'hB, 16'h0030, 8'd2, c_BURST_INCR, c_RESP_OKAY, 0);

        // FIXED burst overwrites one address; neighbour keeps its value.
        r_exp[0] = 8'h11; r_exp[1] = 8'h12;
        write_burst(4'hC, 16'h0020, 8'd1, c_BURST_INCR, 2, c_RESP_OKAY);
        r_exp[0] = 8'h51; r_exp[1] = 8'h52; r_exp[2] = 8'h53;
        write_burst(4'hD, 16'h0020, 8'd2, c_BURST_FIXED, 3, c_RESP_OKAY);
        r_exp[0] = 8'h53; r_exp[1] = 8'h12;
        read_burst(4'hE, 16'h0020, 8'd1, c_BURST_INCR, c_RESP_OKAY, 0);

        // WRAP is served as INCR but flagged.
        r_exp[0] = 8'h61; r_exp[1] = 8'h62;
        write_burst(4'hF, 16'h0060, 8'd1, c_BURST_WRAP, 2, c_RESP_SLVERR);
        read_burst(4'h8, 16'h0060, 8'd1, c_BURST_INCR, c_RESP_OKAY, 0);

        // Reset after beat 2 of a 4-beat write.
        mosi.awid = 4'h2; mosi.awaddr = 16'h0050; mosi.awlen = 8'd3; mosi.awburst = c_BURST_INCR;
        mosi.awvalid = 1'b1;
        #1;
        chk("mid_awready", miso.awready, 1);
        @(posedge clk); #1;
        mosi.awvalid = 1'b0;
        for (int b = 0; b < 2; b++) begin
            mosi.wdata = 8'hC1 + 8'(b); mosi.wlast = 1'b0; mosi.wvalid = 1'b1;
            #1;
            chk("mid_wready", miso.wready, 1);
            @(posedge clk); #1;
        end
        mosi = '0;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_miso", 64'(miso), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        mosi.bready = 1'b1;
        #1;
        chk("mid_bvalid", miso.bvalid, 0);
        chk("mid_wready_idle", miso.wready, 0);
        chk("mid_idle_ready", {miso.awready, miso.arready}, 2'b11);
        @(posedge clk); #1;
        chk("mid_bvalid2", miso.bvalid, 0);
        mosi.bready = 1'b0;
        r_exp[0] = 8'hC1; r_exp[1] = 8'hC2;
        read_burst(4'h3, 16'h0050, 8'd1, c_BURST_INCR, c_RESP_OKAY, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/axi_mem_slave.md
AXI_MEM_SLAVE -- requirements
Module: axi_mem_slave

Interface
REQ-001 SHALL have parameter ID_W_WIDTH, default 4, meaning the write ID width (AWID/BID).
REQ-002 SHALL have parameter ID_R_WIDTH, default 4, meaning the read ID width (ARID/RID).
REQ-003 SHALL have parameter ADDR_WIDTH, default 16, meaning the byte address width.
REQ-004 SHALL have parameter AXI_DATA_WIDTH, default 8, meaning the data bus width in bits (a power of two, at least 8).
REQ-005 SHALL have parameter MEM_DEPTH, default 256, meaning the number of AXI_DATA_WIDTH words stored.
REQ-006 SHALL have port clk, input, 1 bit: single clock; all logic on its rising edge.
REQ-007 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-008 SHALL have port in_mosi_i, input, axi_mosi_t: AW/W/AR channels and BREADY/RREADY from the CPU-side master.
REQ-009 SHALL have port in_miso_o, output, axi_miso_t: AWREADY/WREADY/ARREADY plus the B and R channels to the master.

Function
REQ-010 SHALL implement FSM states IDLE, WRITE, WRESP and READ, and SHALL process one transaction at a time.
REQ-011 In IDLE, SHALL assert AWREADY and ARREADY according to arbitration; all other ready/valid outputs SHALL be low.
REQ-012 When AWVALID and ARVALID are both high in IDLE, SHALL grant alternately, with write first after reset.
REQ-013 When only one request is valid, SHALL grant it regardless of the priority pointer.
REQ-014 On the AW handshake, SHALL latch AWID, AWADDR, AWLEN and AWBURST, clear the beat counter and move to WRITE.
REQ-015 In WRITE, SHALL hold WREADY high and write WDATA to mem[idx] on every W handshake; idx = addr >> log2(AXI_DATA_WIDTH/8).
REQ-016 Burst addressing: INCR SHALL add AXI_DATA_WIDTH/8 per beat; FIXED SHALL keep the address constant.
REQ-017 Burst addressing: WRAP and reserved encodings SHALL be treated as INCR and SHALL flag SLVERR.
REQ-018 A write beat SHALL be dropped (memory unchanged) when idx >= MEM_DEPTH, and the burst SHALL be flagged SLVERR.
REQ-019 WRITE SHALL end on beat AWLEN+1.
REQ-020 WLAST low on the final beat, or high on an earlier beat, SHALL flag SLVERR; the beat count alone governs termination.
REQ-021 After the final beat, SHALL enter WRESP and assert BVALID with BID=latched AWID and BRESP=SLVERR if flagged, else OKAY.
REQ-022 BVALID and BRESP SHALL be held stable until BREADY, then SHALL return to IDLE.
REQ-023 On the AR handshake, SHALL latch ARID, ARADDR, ARLEN and ARBURST and move to READ.
REQ-024 RVALID SHALL rise the cycle after the AR handshake (one-cycle latency).
REQ-025 In READ, RDATA SHALL be mem[idx], or 0 with RRESP=SLVERR for an out-of-range beat; RID SHALL be the latched ARID.
REQ-026 In READ, RLAST SHALL be high only on beat ARLEN+1.
REQ-027 RDATA, RRESP, RID and RLAST SHALL be held stable while RVALID is high and RREADY is low.
REQ-028 On each R handshake, the address and counter SHALL advance; the final handshake SHALL return to IDLE.
REQ-029 A read of the address just written SHALL return the new data; no bypass is needed because transactions are serialized.
REQ-030 The beat counter SHALL be 8 bits wide (AXI4 AWLEN/ARLEN up to 255), and the address SHALL wrap modulo 2^ADDR_WIDTH.

Reset
REQ-031 On rst_n low, the FSM SHALL enter IDLE and all in_miso_o fields SHALL be 0, except that AWREADY and ARREADY SHALL follow IDLE arbitration once rst_n is high.
REQ-032 On reset, the priority pointer SHALL select write first and the error flag and counters SHALL clear.
REQ-033 Memory contents SHALL NOT be reset.
REQ-034 Reset mid-burst SHALL abandon the transaction with no B or R response; beats already written SHALL persist.

Structure
REQ-035 AXI burst encodings (FIXED/INCR/WRAP) and response encodings (OKAY/SLVERR) SHALL be constants in the shared AXI package next to axi_mosi_t/axi_miso_t.
REQ-036 The storage array SHALL be a sub-module axi_mem_slave_array: one write port, one combinational read port, MEM_DEPTH x AXI_DATA_WIDTH.
REQ-037 The FSM, arbitration and address generation SHALL reside in axi_mem_slave.

Verification
REQ-038 Write AWADDR=0x10, AWLEN=3, INCR, data 0xA1..0xA4, BREADY=1 -> BRESP=OKAY with BID=AWID; then read ARLEN=3 -> 0xA1..0xA4 with RLAST only on beat 4.
REQ-039 AWVALID and ARVALID both raised in the same cycle after reset, twice -> first grant write, second grant read.
REQ-040 Read ARLEN=1 with RREADY low for 5 cycles -> RVALID high and RDATA/RID/RLAST unchanged; completes after RREADY rises.
REQ-041 Write to AWADDR=0x0100 with MEM_DEPTH=256 and AXI_DATA_WIDTH=8 -> BRESP=SLVERR; a read of 0x0100 returns 0 with SLVERR, memory unchanged.
REQ-042 Write AWLEN=2 with WLAST on beat 2 -> three beats accepted and BRESP=SLVERR; FIXED burst AWLEN=2 -> only the last datum remains at the address.
REQ-043 rst_n low during beat 2 of an AWLEN=3 write -> no BVALID, IDLE after reset release, beats 1-2 readable.
